// File: rtl/life_gen_engine.sv
// Row-at-a-time Game of Life (B3/S23) engine over a 4 x WIDTH grid with a double-buffered next generation.
// Define LIFE_TORUS_EN to wrap column neighbours; rows always wrap mod 4.
module life_gen_engine #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [1:0]           pos,
  input  logic                 write_mem,
  input  logic                 load,
  input  logic [1:0]           load_row,
  input  logic [WIDTH-1:0]     load_data,
  output logic [4*WIDTH-1:0]   grid_out,
  output logic                 stage_valid,
  output logic [7:0]           generation,
  output logic                 gen_done,
  output logic                 commit_err
);

  logic [WIDTH-1:0] cur [4];
  logic [WIDTH-1:0] nxt [4];
  logic [WIDTH-1:0] stage;
  logic [1:0]       stage_pos;
  logic [3:0]       mask;

  logic [WIDTH-1:0] row_up, row_mid, row_dn;
  logic [WIDTH+1:0] ext_up, ext_mid, ext_dn;
  logic [WIDTH-1:0] next_row;
  logic [3:0]       cnt;

  logic             commit;
  logic [3:0]       mask_after;
  logic             swap;

  assign row_up  = cur[pos - 2'd1];
  assign row_mid = cur[pos];
  assign row_dn  = cur[pos + 2'd1];

  // Rows padded with the column -1 (bit 0) and column WIDTH (top bit) neighbours.
`ifdef LIFE_TORUS_EN
  assign ext_up  = {row_up[0],  row_up,  row_up[WIDTH-1]};
  assign ext_mid = {row_mid[0], row_mid, row_mid[WIDTH-1]};
  assign ext_dn  = {row_dn[0],  row_dn,  row_dn[WIDTH-1]};
`else
  assign ext_up  = {1'b0, row_up,  1'b0};
  assign ext_mid = {1'b0, row_mid, 1'b0};
  assign ext_dn  = {1'b0, row_dn,  1'b0};
`endif

  always_comb begin
    next_row = '0;
    cnt      = '0;
    for (int unsigned c = 0; c < WIDTH; c++) begin
      cnt = {3'b000, ext_up[c]}  + {3'b000, ext_up[c+1]}  + {3'b000, ext_up[c+2]}
          + {3'b000, ext_mid[c]}                          + {3'b000, ext_mid[c+2]}
          + {3'b000, ext_dn[c]}  + {3'b000, ext_dn[c+1]}  + {3'b000, ext_dn[c+2]};
      next_row[c] = (cnt == 4'd3) || (row_mid[c] && (cnt == 4'd2));
    end
  end

  assign commit     = write_mem && stage_valid;
  assign mask_after = mask | (4'b0001 << stage_pos);
  assign swap       = commit && (mask_after == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < 4; r++) begin
        cur[r] <= '0;
        nxt[r] <= '0;
      end
      stage       <= '0;
      stage_pos   <= '0;
      mask        <= '0;
      stage_valid <= 1'b0;
      gen_done    <= 1'b0;
      commit_err  <= 1'b0;
      generation  <= '0;
    end else begin
      gen_done <= 1'b0;
      if (load) begin
        cur[load_row] <= load_data;
        mask          <= '0;
        stage_valid   <= 1'b0;
        generation    <= '0;
      end else begin
        if (write_mem && !stage_valid)
          commit_err <= 1'b1;
        if (commit) begin
          nxt[stage_pos] <= stage;
          // The completing row bypasses nxt so all four rows land in cur on this edge.
          if (swap) begin
            for (int unsigned r = 0; r < 4; r++)
              cur[r] <= (2'(r) == stage_pos) ? stage : nxt[r];
            mask       <= '0;
            generation <= generation + 8'd1;
            gen_done   <= 1'b1;
          end else begin
            mask <= mask_after;
          end
        end
        if (run) begin
          stage       <= next_row;
          stage_pos   <= pos;
          stage_valid <= 1'b1;
        end else if (commit) begin
          stage_valid <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    grid_out = '0;
    for (int unsigned r = 0; r < 4; r++)
      grid_out[r*WIDTH +: WIDTH] = cur[r];
  end

endmodule
